regfile32x64: RTL

REGFILE32X64 -- requirements
Module: regfile32x64

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile32x64_reg64.sv | 27 ++
 rtl/regfile32x64.sv | 72 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing for the 32 x 64-bit register file.
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int NREG     = 32;
  localparam int ZERO_REG = 31;
  localparam int IDX_W    = 5;

  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/regfile32x64_reg64.sv
// One storage word with load enable and asynchronous active-low clear.
module reg64 #(
  parameter int DATA_W = regfile_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en) data_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/regfile32x64.sv
// Two-read, one-write register file with a hardwired-zero index and
// write-through bypass on both read ports.
module regfile32x64
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int NREG     = regfile_pkg::NREG,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [IDX_W-1:0]  WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [IDX_W-1:0]  ReadRegister1,
  input  logic [IDX_W-1:0]  ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  // Writes are armed one edge after reset release, so a write that lands on
  // the releasing edge itself is dropped rather than racing the clear.
  logic arm_q;
  logic arm_d;

  always_comb begin
    arm_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) arm_q <= 1'b0;
    else        arm_q <= arm_d;
  end

  logic              wr_ok;
  logic [NREG-1:0]   we_onehot;
  logic [DATA_W-1:0] reg_q [NREG];

  assign wr_ok = RegWrite & arm_q & reset;

  always_comb begin
    we_onehot = '0;
    for (int i = 0; i < NREG; i++) begin
      if (i != ZERO_REG && WriteRegister == IDX_W'(i)) we_onehot[i] = wr_ok;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_word
    if (g != ZERO_REG) begin : g_reg
      reg64 #(.DATA_W(DATA_W)) u_reg (
        .clk   (clk),
        .rst_n (reset),
        .en    (we_onehot[g]),
        .d     (WriteData),
        .q     (reg_q[g])
      );
    end else begin : g_zero
      assign reg_q[g] = '0;
    end
  end

  always_comb begin
    ReadData1 = reg_q[ReadRegister1];
    if (wr_ok && WriteRegister == ReadRegister1) ReadData1 = WriteData;
    if (!reset || ReadRegister1 == IDX_W'(ZERO_REG)) ReadData1 = '0;

    ReadData2 = reg_q[ReadRegister2];
    if (wr_ok && WriteRegister == ReadRegister2) ReadData2 = WriteData;
    if (!reset || ReadRegister2 == IDX_W'(ZERO_REG)) ReadData2 = '0;
  end

endmodule
